alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the team's 4-bit registered ALU. It executes the same 16-operation set on signed WIDTH-bit operands and returns a full-precision 2·WIDTH-bit result plus status flags. Single-cycle ops issue back-to-back; multiply runs as an iterative shift-add over WIDTH cycles. It sits between an operand producer and a result consumer, with valid/ready flow control on both sides.

## Interface
- WIDTH, default 4: operand width in bits; legal range is 2 to 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B.
- sel  in  4  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- y  out  2·WIDTH  signed result.
- flags  out  4  {ovf, carry, neg, zero}.

## Operation
- Accept occurs on a rising edge with in_valid && in_ready. On accept, a, b and sel are captured into internal registers; the inputs are then don't-care.
- Opcodes with sel[3]=0:
  - 000: A+1
  - 001: B+1
  - 010: A
  - 011: B
  - 100: A−1
  - 101: A·B (iterative)
  - 110: A+B
  - 111: A−B
- Opcodes with sel[3]=1, computed on WIDTH bits:
  - 000: ~A
  - 001: ~B
  - 010: A&B
  - 011: A|B
  - 100: A^B
  - 101: ~(A^B)
  - 110: ~(A&B)
  - 111: ~(A|B)
- Width rules:
  - Arithmetic results are computed sign-extended to 2·WIDTH bits and are exact; y never wraps.
  - Logic results are computed on WIDTH bits, then sign-extended to 2·WIDTH.
  - Multiply is signed with an exact 2·WIDTH-bit product. −2^(WIDTH−1) · −2^(WIDTH−1) yields +2^(2·WIDTH−2).
- Flags:
  - zero = (y==0).
  - neg = y[2·WIDTH−1].
  - carry: for add/inc ops, the carry-out of the unsigned WIDTH-bit sum. For sub/dec ops, the borrow (unsigned minuend < subtrahend). 0 for all other ops.
  - ovf: 1 when the signed WIDTH-bit result of add/sub/inc/dec overflows. 0 for all other ops, including multiply.
- FSM states:
  - IDLE: ready to accept.
  - MUL: iterating; holds a cycle counter from 0 to WIDTH−1.
  - HOLD: result is waiting for out_ready.
- FSM transitions:
  - IDLE→MUL on accepting opcode 0101.
  - MUL→HOLD after the WIDTH-th iteration.
  - Any state→IDLE when the result is taken and no new op is accepted.
  - A non-multiply accept goes directly to an output-valid state.
- in_ready = (state != MUL) && (!out_valid || out_ready). Accepting a new op in the same cycle the result is taken is allowed; this gives full throughput for non-multiply ops.
- Once out_valid is high, y and flags stay stable until the cycle in which out_ready is sampled high.

## Timing
- Reset (rst_n=0 at a rising edge) forces:
  - state=IDLE, out_valid=0, y=0, flags=0;
  - in_ready=1 in the first cycle after reset releases.
- Non-multiply ops: out_valid rises at the edge after the accept edge, giving 1-cycle latency.
- Multiply: out_valid rises WIDTH+1 edges after the accept edge, giving 5 cycles at WIDTH=4. in_ready stays 0 from the accept edge until out_valid is high.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and nothing is accepted.
- Reset asserted mid-multiply aborts the operation. No out_valid is produced for it, and all outputs take their reset values at that edge.
- in_valid asserted while in_ready=0 is ignored. The producer must hold its request until it is accepted.

## Test plan
All scenarios use WIDTH=4.
- Reset: hold rst_n=0 for 2 cycles with random inputs → out_valid=0, y=0x00, flags=0; in_ready=1 after release.
- Add overflow: A=7, B=7, sel=0110 → one cycle later y=0x0E, ovf=1, carry=0, neg=0.
- Decrement: A=−8, sel=0100 → y=0xF7 (−9), ovf=1, carry=0, neg=1.
- Logic extension: A=5, sel=1000 → y=0xFA.
- Multiply latency: A=7, B=−8, sel=0101 → y=0xC8 (−56) exactly 5 cycles after accept, with in_ready=0 throughout.
- Multiply corner: A=−8, B=−8 → y=0x40 (64).
- Back-to-back with backpressure: issue 4 non-multiply ops on consecutive cycles, with out_ready held 0 for 3 cycles mid-stream → results arrive in order, none lost or duplicated, y is stable while stalled, and in_ready=0 during the stall.
- Reset mid-multiply: assert rst_n=0 on the 3rd MUL cycle → no result is emitted; a following add 1+1 returns y=0x02.

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked signed ALU with full-precision result and iterative multiply
// Non-multiply ops retire through a single output register; multiply iterates shift-add in MUL.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic [3:0]         flags
);

  localparam int YW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [YW-1:0]   acc_q, acc_d;
  logic [YW-1:0]   y_q, y_d;
  logic [3:0]      flags_q, flags_d;

  logic [YW-1:0]    ax, bx, res, pp, prod;
  logic [WIDTH:0]   usum;
  logic [WIDTH-1:0] lres;
  logic             carry, arith, ovf;
  logic             accept, take;

  always_comb begin : datapath
    ax    = {{WIDTH{a[WIDTH-1]}}, a};
    bx    = {{WIDTH{b[WIDTH-1]}}, b};
    res   = '0;
    lres  = '0;
    usum  = '0;
    carry = 1'b0;
    arith = 1'b0;
    if (!sel[3]) begin
      case (sel[2:0])
        3'b000: begin
          res   = ax + YW'(1);
          usum  = {1'b0, a} + (WIDTH+1)'(1);
          carry = usum[WIDTH];
          arith = 1'b1;
        end
        3'b001: begin
          res   = bx + YW'(1);
          usum  = {1'b0, b} + (WIDTH+1)'(1);
          carry = usum[WIDTH];
          arith = 1'b1;
        end
        3'b010: res = ax;
        3'b011: res = bx;
        3'b100: begin
          res   = ax - YW'(1);
          carry = (a == '0);
          arith = 1'b1;
        end
        3'b110: begin
          res   = ax + bx;
          usum  = {1'b0, a} + {1'b0, b};
          carry = usum[WIDTH];
          arith = 1'b1;
        end
        3'b111: begin
          res   = ax - bx;
          carry = (a < b);
          arith = 1'b1;
        end
        default: res = '0;
      endcase
    end else begin
      case (sel[2:0])
        3'b000:  lres = ~a;
        3'b001:  lres = ~b;
        3'b010:  lres = a & b;
        3'b011:  lres = a | b;
        3'b100:  lres = a ^ b;
        3'b101:  lres = ~(a ^ b);
        3'b110:  lres = ~(a & b);
        default: lres = ~(a | b);
      endcase
      res = {{WIDTH{lres[WIDTH-1]}}, lres};
    end
    // Exact result overflows WIDTH signed bits iff its top WIDTH+1 bits are not all equal.
    ovf = arith && (res[YW-1:WIDTH-1] != '0) && (res[YW-1:WIDTH-1] != '1);
  end

  always_comb begin : mul_step
    pp = {{WIDTH{a_q[WIDTH-1]}}, a_q} << cnt_q;
    // The multiplier MSB carries negative weight in two's complement.
    if (!b_q[cnt_q]) begin
      prod = acc_q;
    end else if (cnt_q == CW'(WIDTH - 1)) begin
      prod = acc_q - pp;
    end else begin
      prod = acc_q + pp;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign in_ready  = (state_q != MUL) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign y         = y_q;
  assign flags     = flags_q;

  always_comb begin : fsm
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    y_d     = y_q;
    flags_d = flags_q;
    case (state_q)
      MUL: begin
        acc_d = prod;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = HOLD;
          y_d     = prod;
          flags_d = {2'b00, prod[YW-1], prod == '0};
        end
      end
      default: begin
        if (take) begin
          state_d = IDLE;
        end
      end
    endcase
    if (accept) begin
      a_d = a;
      b_d = b;
      if (sel == 4'b0101) begin
        state_d = MUL;
        cnt_d   = '0;
        acc_d   = '0;
      end else begin
        state_d = HOLD;
        y_d     = res;
        flags_d = {ovf, carry, res[YW-1], res == '0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe with directed corners and random traffic
module tb_alu_pipe;

  localparam int W  = 4;
  localparam int YW = 2 * W;

  typedef struct {
    logic [YW-1:0] y;
    logic [3:0]    f;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [3:0]    sel;
  logic [YW-1:0] y;
  logic [3:0]    flags;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  bit   rand_bp = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flags(flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed/unsigned operand values.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] isel);
    exp_t e;
    int sa, sb, ua, ub, r, lv, lim;
    bit c, v, arith;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    ua = int'(ia);
    ub = int'(ib);
    lim = 1 << W;
    c = 0; v = 0; arith = 0; r = 0; lv = 0;
    case (isel)
      4'd0: begin r = sa + 1;  c = (ua + 1) >= lim;  arith = 1; end
      4'd1: begin r = sb + 1;  c = (ub + 1) >= lim;  arith = 1; end
      4'd2: r = sa;
      4'd3: r = sb;
      4'd4: begin r = sa - 1;  c = ua < 1;           arith = 1; end
      4'd5: r = sa * sb;
      4'd6: begin r = sa + sb; c = (ua + ub) >= lim; arith = 1; end
      4'd7: begin r = sa - sb; c = ua < ub;          arith = 1; end
      default: begin
        case (isel)
          4'd8:    lv = ~ua;
          4'd9:    lv = ~ub;
          4'd10:   lv = ua & ub;
          4'd11:   lv = ua | ub;
          4'd12:   lv = ua ^ ub;
          4'd13:   lv = ~(ua ^ ub);
          4'd14:   lv = ~(ua & ub);
          default: lv = ~(ua | ub);
        endcase
        lv = lv & (lim - 1);
        r  = (lv >= lim / 2) ? lv - lim : lv;
      end
    endcase
    if (arith) v = (r > lim / 2 - 1) || (r < -(lim / 2));
    e.y = YW'(r);
    e.f = {v, c, r < 0, r == 0};
    return e;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] isel,
                       input bit directed, input logic [YW-1:0] ey, input logic [3:0] ef,
                       input bit push);
    bit rdy, ok;
    int n;
    exp_t e;
    ok = 0;
    n  = 0;
    a = ia; b = ib; sel = isel; in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (rdy) ok = 1;
    end
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sel = 4'($urandom);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op sel=%0h not accepted within 200 cycles", isel);
    end else if (push) begin
      if (directed) begin
        e.y = ey;
        e.f = ef;
      end else begin
        e = model(ia, ib, isel);
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(sb_q.size()), 0);
  endtask

  logic [YW-1:0] held_y;
  logic [3:0]    held_f;
  bit            held = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else if (out_valid) begin
      if (held) begin
        check("stable_y", 32'(y), 32'(held_y));
        check("stable_flags", 32'(flags), 32'(held_f));
      end
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: got y=0x%0h flags=0x%0h with nothing expected", y, flags);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result_y", 32'(y), 32'(e.y));
          check("result_flags", 32'(flags), 32'(e.f));
        end
        held = 0;
      end else begin
        held   = 1;
        held_y = y;
        held_f = flags;
      end
    end else begin
      held = 0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom % 4) != 0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sel = '0;

    repeat (2) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); sel = 4'($urandom);
      @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_y", 32'(y), 0);
      check("reset_flags", 32'(flags), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    issue(4'd7, 4'd7, 4'b0110, 1, 8'h0E, 4'b1000, 1);
    @(negedge clk);
    check("add_latency_valid", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    issue(4'h8, 4'h0, 4'b0100, 1, 8'hF7, 4'b1010, 1);
    issue(4'd5, 4'h0, 4'b1000, 1, 8'hFA, 4'b0010, 1);
    drain("drain_directed");

    issue(4'd7, 4'h8, 4'b0101, 1, 8'hC8, 4'b0010, 1);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      check("mul_busy_in_ready", 32'(in_ready), 0);
    end
    check("mul_latency", 32'(k), 5);
    @(posedge clk);
    #1;
    issue(4'h8, 4'h8, 4'b0101, 1, 8'h40, 4'b0000, 1);
    drain("drain_mul");

    fork
      begin
        issue(4'd1, 4'd2, 4'b0110, 0, '0, '0, 1);
        issue(4'd3, 4'hC, 4'b1010, 0, '0, '0, 1);
        issue(4'hD, 4'd6, 4'b0111, 0, '0, '0, 1);
        issue(4'd5, 4'h9, 4'b1100, 0, '0, '0, 1);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 0);
          check("stall_out_valid", 32'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    issue(4'd3, 4'd3, 4'b0101, 0, '0, '0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_y", 32'(y), 0);
    check("abort_flags", 32'(flags), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(4'd1, 4'd1, 4'b0110, 1, 8'h02, 4'b0000, 1);
    drain("drain_after_abort");

    rand_bp = 1;
    repeat (150) issue(W'($urandom), W'($urandom), 4'($urandom), 0, '0, '0, 1);
    rand_bp = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
